// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART framing constants, transmitter state type and baud-timing helpers.
// Also consumed by the serial receive path.
package uart_tx_buffered_pkg;

    localparam logic        UART_START_BIT = 1'b0;
    localparam logic        UART_STOP_BIT  = 1'b1;
    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_FRAME_W   = UART_DATA_BITS + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned symbol_cycles);
        return (symbol_cycles > 1) ? $clog2(symbol_cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
// Full/empty come from the occupancy count; pointers wrap at DEPTH (power of two).
module sync_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A write is refused while full even if a read frees a slot on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: ready/valid byte intake into a small FIFO,
// serialised LSB first at BAUD_RATE onto a registered, idle-high line.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W            = cnt_width(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]       IDX_LAST    = 3'(UART_DATA_BITS - 1);

    logic       fifo_full, fifo_empty, fifo_pop, push;
    logic [7:0] fifo_dout;

    uart_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [UART_FRAME_W-1:0] shift_q, shift_d;
    logic                    serial_out_q, serial_out_d;
    logic                    tx_busy_q, tx_busy_d;
    logic                    bit_end;

    assign data_in_ready = !fifo_full;
    assign push          = data_in_valid && data_in_ready;
    assign serial_out    = serial_out_q;
    assign tx_busy       = tx_busy_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (push),
        .din   (data_in),
        .full  (fifo_full),
        .rd_en (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        // Line and busy flag are registered copies of the current state, so the
        // pin lags the state by one cycle and never glitches.
        serial_out_d = (state_q == ST_IDLE) ? UART_STOP_BIT : shift_q[0];
        tx_busy_d    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = {UART_STOP_BIT, fifo_dout, UART_START_BIT};
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = {UART_STOP_BIT, shift_q[UART_FRAME_W-1:1]};
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {UART_STOP_BIT, shift_q[UART_FRAME_W-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = {UART_STOP_BIT, fifo_dout, UART_START_BIT};
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '1;
            serial_out_q <= UART_STOP_BIT;
            tx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            serial_out_q <= serial_out_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: queue/timer line model, mid-bit sampling receiver
// and directed scenarios with hand-computed expectations.
module tb_uart_tx_buffered;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int SET        = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * SET;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx_buffered #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line model: a byte queue plus a frame timer of FRAME cycles per byte.
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] cur_byte = 8'h00;
    int         rem = 0;
    int         bit_no;
    logic       st_line = 1'b1, st_busy = 1'b0;
    logic       exp_line = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
    int         exp_count = 0;
    logic       m_full, m_nonempty;
    logic       model_live = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            sent_q.delete();
            rem        = 0;
            st_line    = 1'b1;
            st_busy    = 1'b0;
            exp_line   = 1'b1;
            exp_busy   = 1'b0;
            model_live = 1'b1;
        end else begin
            m_full     = (mq.size() == FIFO_DEPTH);
            m_nonempty = (mq.size() != 0);
            exp_line   = st_line;
            exp_busy   = st_busy;
            if (rem > 0) rem--;
            if (rem == 0 && m_nonempty) begin
                cur_byte = mq.pop_front();
                sent_q.push_back(cur_byte);
                rem = FRAME;
            end
            if (data_in_valid && !m_full) mq.push_back(data_in);
            if (rem > 0) begin
                bit_no  = (FRAME - rem) / SET;
                st_line = (bit_no == 0) ? 1'b0 : (bit_no == 9) ? 1'b1 : cur_byte[bit_no-1];
                st_busy = 1'b1;
            end else begin
                st_line = 1'b1;
                st_busy = 1'b0;
            end
        end
        exp_count = mq.size();
        exp_ready = (mq.size() != FIFO_DEPTH);
    end

    // Compare against the model every cycle, and decode the line like a receiver.
    int         neg_cyc = 0;
    logic       prev_line = 1'b1;
    logic       rx_active = 1'b0;
    int         rx_t = 0, rx_i;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_log[$];
    int         falls[$];
    int         rx_ferr = 0;

    initial forever begin
        @(negedge clk);
        neg_cyc++;
        if (model_live) begin
            check("serial_out", 32'(serial_out), 32'(exp_line));
            check("tx_busy", 32'(tx_busy), 32'(exp_busy));
            check("fifo_count", 32'(fifo_count), 32'(exp_count));
            check("data_in_ready", 32'(data_in_ready), 32'(exp_ready));
        end
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (prev_line && serial_out === 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                falls.push_back(neg_cyc);
            end
        end else begin
            rx_t++;
        end
        if (rx_active && (rx_t % SET) == SET / 2) begin
            rx_i = rx_t / SET;
            if (rx_i == 0) begin
                if (serial_out !== 1'b0) rx_ferr++;
                check("rx_start_bit", 32'(serial_out), 32'd0);
            end else if (rx_i < 9) begin
                rx_byte[rx_i-1] = serial_out;
            end else begin
                if (serial_out !== 1'b1) rx_ferr++;
                check("rx_stop_bit", 32'(serial_out), 32'd1);
                rx_active = 1'b0;
                rx_log.push_back(rx_byte);
                if (sent_q.size() == 0) check("rx_unexpected_frame", 32'd1, 32'd0);
                else check("rx_byte_order", 32'(rx_byte), 32'(sent_q.pop_front()));
            end
        end
        prev_line = serial_out;
    end

    task automatic wait_idle();
        int t = 0;
        while (!(tx_busy === 1'b0 && fifo_count === 3'd0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    int   a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   busy_cycles, line_errs, quiet, pushes, t;
    int   acc_t[6];
    logic r, rise_seen;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_serial_out", 32'(serial_out), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        check("reset_ready", 32'(data_in_ready), 32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte 0xA5
        wait_idle();
        rx_log.delete();
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        check("a5_count_after_push", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("a5_line_before_start", 32'(serial_out), 32'd1);
        check("a5_busy_before_start", 32'(tx_busy), 32'd0);
        check("a5_count_after_pop", 32'(fifo_count), 32'd0);
        busy_cycles = 0;
        line_errs   = 0;
        for (int j = 0; j < 120; j++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) busy_cycles++;
            if (j < FRAME) begin
                if (serial_out !== 1'(a5_bits[j / SET])) line_errs++;
                if (j == 0) check("a5_start_at_k2", 32'(serial_out), 32'd0);
                if ((j % SET) == SET / 2) check($sformatf("a5_bit%0d", j / SET), 32'(serial_out), 32'(a5_bits[j / SET]));
            end else if (serial_out !== 1'b1) begin
                line_errs++;
            end
        end
        check("a5_busy_cycles", 32'(busy_cycles), 32'd100);
        check("a5_line_errs", 32'(line_errs), 32'd0);
        check("a5_rx_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) check("a5_rx_byte", 32'(rx_log[0]), 32'hA5);

        // Burst of six bytes with valid held high, including a full-FIFO pop edge
        wait_idle();
        rx_log.delete();
        falls.delete();
        data_in = 8'h00;
        data_in_valid = 1'b1;
        pushes = 0;
        t = 0;
        rise_seen = 1'b0;
        while (pushes < 6 && t < 400) begin
            r = data_in_ready;
            @(negedge clk);
            t++;
            if (r) begin
                acc_t[pushes] = t;
                pushes++;
                if (pushes < 6) data_in = 8'(pushes);
                else data_in_valid = 1'b0;
                if (pushes == 5) begin
                    check("burst_ready_low_after_5", 32'(data_in_ready), 32'd0);
                    check("burst_count_full", 32'(fifo_count), 32'd4);
                end
            end else if (pushes == 5 && data_in_ready === 1'b1 && !rise_seen) begin
                rise_seen = 1'b1;
                check("full_pop_count", 32'(fifo_count), 32'd3);
                check("full_pop_edge", 32'(t - acc_t[0]), 32'd101);
            end
        end
        data_in_valid = 1'b0;
        check("burst_pushes", 32'(pushes), 32'd6);
        if (pushes == 6) begin
            check("burst_fifth_push", 32'(acc_t[4] - acc_t[0]), 32'd4);
            check("burst_sixth_push", 32'(acc_t[5] - acc_t[0]), 32'd102);
        end
        wait_idle();
        repeat (20) @(negedge clk);
        check("burst_frames", 32'(falls.size()), 32'd6);
        for (int i = 1; i < 6 && i < falls.size(); i++)
            check($sformatf("burst_gap%0d", i), 32'(falls[i] - falls[i-1]), 32'd100);
        check("burst_rx_count", 32'(rx_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < rx_log.size(); i++)
            check($sformatf("burst_rx%0d", i), 32'(rx_log[i]), 32'(i));

        // Reset during DATA bit 3 with two bytes buffered
        wait_idle();
        rx_log.delete();
        data_in = 8'h11;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h22;
        @(negedge clk);
        data_in = 8'h33;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (43) @(negedge clk);
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        check("pre_reset_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_serial_out", 32'(serial_out), 32'd1);
        check("midreset_tx_busy", 32'(tx_busy), 32'd0);
        check("midreset_fifo_count", 32'(fifo_count), 32'd0);
        check("midreset_ready", 32'(data_in_ready), 32'd1);
        rst_n = 1'b1;
        busy_cycles = 0;
        line_errs   = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (tx_busy !== 1'b0) busy_cycles++;
            if (serial_out !== 1'b1) line_errs++;
        end
        check("post_reset_busy", 32'(busy_cycles), 32'd0);
        check("post_reset_line", 32'(line_errs), 32'd0);
        check("post_reset_rx", 32'(rx_log.size()), 32'd0);

        // Idle stability
        quiet = 0;
        for (int j = 0; j < 500; j++) begin
            @(negedge clk);
            if (serial_out === 1'b1 && fifo_count === 3'd0) quiet++;
        end
        check("idle_quiet_cycles", 32'(quiet), 32'd500);

        // 0xFF then 0x00 through the reference receiver
        wait_idle();
        rx_log.delete();
        rx_ferr = 0;
        data_in = 8'hFF;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h00;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (230) @(negedge clk);
        check("ff00_rx_count", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() >= 2) begin
            check("ff00_rx0", 32'(rx_log[0]), 32'hFF);
            check("ff00_rx1", 32'(rx_log[1]), 32'h00);
        end
        check("ff00_framing_errors", 32'(rx_ferr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
